// File: rtl/ps2_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_transmitter
// Description : Host-to-device PS/2 command transmitter. It inhibits the bus,
//               issues request-to-send, then clocks out the data, parity and
//               stop bits on device clock edges and checks the device ack.
//               Optional macro PS2_TX_TIMEOUT_EN adds a device-silence timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 200,
    parameter int FILTER_CYCLES  = 19,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       done,
    output logic       ack_err
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT   = 3'd1;
    localparam logic [2:0] c_ST_RTS       = 3'd2;
    localparam logic [2:0] c_ST_SEND      = 3'd3;
    localparam logic [2:0] c_ST_ACK       = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

    localparam int c_SEQ_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
`ifdef PS2_TX_TIMEOUT_EN
    // One counter times INHIBIT, RTS and the SEND/ACK silence window.
    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > c_SEQ_MAX) ? TIMEOUT_CYCLES : c_SEQ_MAX;
`else
    localparam int c_CNT_MAX = c_SEQ_MAX;
`endif
    localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RTS_LAST = c_CNT_W'(RTS_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam int c_FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [c_FLT_W-1:0] c_FLT_LAST = c_FLT_W'(FILTER_CYCLES - 1);

    if (INHIBIT_CYCLES < 1 || RTS_CYCLES < 1 || FILTER_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_transmitter: all cycle parameters must be at least 1");
    end

    logic [1:0]         w_raw;
    logic [1:0]         w_filt;
    logic               r_kclk_filt_d;
    logic               w_kclk_fall;

    logic [2:0]         r_state;
    logic [7:0]         r_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic               r_kclk_oe;
    logic               r_kdata_oe;
    logic               r_done;
    logic               r_ack_err;

    assign w_raw = {kdata, kclk};

    // Index 0 is kclk, index 1 is kdata; both idle high out of reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic               r_sync1;
        logic               r_sync2;
        logic               r_filt;
        logic [c_FLT_W-1:0] r_flt_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1   <= 1'b1;
                r_sync2   <= 1'b1;
                r_filt    <= 1'b1;
                r_flt_cnt <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_filt) begin
                    r_flt_cnt <= '0;
                end else if (r_flt_cnt == c_FLT_LAST) begin
                    r_filt    <= r_sync2;
                    r_flt_cnt <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 1'b1;
                end
            end
        end

        assign w_filt[gi] = r_filt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kclk_filt_d <= 1'b1;
        end else begin
            r_kclk_filt_d <= w_filt[0];
        end
    end

    assign w_kclk_fall = r_kclk_filt_d & ~w_filt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_data     <= '0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_kclk_oe  <= 1'b0;
            r_kdata_oe <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_kclk_oe  <= 1'b0;
                    r_kdata_oe <= 1'b0;
                    if (tx_valid) begin
                        r_data    <= tx_data;
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        r_kclk_oe <= 1'b1;
                        r_state   <= c_ST_INHIBIT;
                    end
                end
                c_ST_INHIBIT: begin
                    if (r_cnt == c_INH_LAST) begin
                        r_cnt      <= '0;
                        r_kdata_oe <= 1'b1;
                        r_state    <= c_ST_RTS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RTS: begin
                    // Releasing kclk while holding kdata low is the start bit.
                    if (r_cnt == c_RTS_LAST) begin
                        r_cnt     <= '0;
                        r_kclk_oe <= 1'b0;
                        r_state   <= c_ST_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_SEND: begin
                    if (w_kclk_fall) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 1'b1;
                        if (r_bit < 4'd8) begin
                            r_kdata_oe <= ~r_data[r_bit[2:0]];
                        end else if (r_bit == 4'd8) begin
                            // Odd parity bit is ~^data, so the pull-down is ^data.
                            r_kdata_oe <= ^r_data;
                        end else begin
                            r_kdata_oe <= 1'b0;
                            r_state    <= c_ST_ACK;
                        end
                    end else begin
`ifdef PS2_TX_TIMEOUT_EN
                        if (r_cnt == c_TO_LAST) begin
                            r_kclk_oe  <= 1'b0;
                            r_kdata_oe <= 1'b0;
                            r_ack_err  <= 1'b1;
                            r_state    <= c_ST_WAIT_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`endif
                    end
                end
                c_ST_ACK: begin
                    if (w_kclk_fall) begin
                        r_cnt <= '0;
                        if (!w_filt[1]) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ack_err <= 1'b1;
                        end
                        r_state <= c_ST_WAIT_IDLE;
                    end else begin
`ifdef PS2_TX_TIMEOUT_EN
                        if (r_cnt == c_TO_LAST) begin
                            r_kclk_oe  <= 1'b0;
                            r_kdata_oe <= 1'b0;
                            r_ack_err  <= 1'b1;
                            r_state    <= c_ST_WAIT_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`endif
                    end
                end
                c_ST_WAIT_IDLE: begin
                    r_kclk_oe  <= 1'b0;
                    r_kdata_oe <= 1'b0;
                    if (w_filt[0] && w_filt[1]) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_kclk_oe  <= 1'b0;
                    r_kdata_oe <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == c_ST_IDLE);
    assign kclk_oe  = r_kclk_oe;
    assign kdata_oe = r_kdata_oe;
    assign done     = r_done;
    assign ack_err  = r_ack_err;

endmodule
`default_nettype wire
